// File: rtl/mem_ctrl.sv
// Shared IF/MEM memory controller: arbitrates the two requesters and serialises 8/16/32-bit
// accesses onto a byte-wide synchronous RAM bus, little-endian, with load sign/zero extension.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size,
  input  logic              mem_sext,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] wdata_q;
  logic        owner_mem_q;
  logic [31:0] asm_q, asm_d;
  logic [31:0] if_rdata_q, mem_rdata_q;

  logic        grant_mem, grant_if;
  logic [2:0]  nbytes;
  logic        rd_last;
  logic [1:0]  beat_idx;
  logic [31:0] cur_addr;
  logic [31:0] ext_data;

  // MEM always wins a simultaneous request; grants only happen from IDLE.
  assign grant_mem = (state_q == StIdle) && mem_req;
  assign grant_if  = (state_q == StIdle) && !mem_req && if_req;

  always_comb begin
    nbytes = 3'd4;
    unique case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign rd_last  = (state_q == StRead) && (cnt_q == nbytes);
  // Byte arriving this cycle belongs to the address presented one cycle earlier.
  assign beat_idx = cnt_q[1:0] - 2'd1;
  assign cur_addr = addr_q + {29'd0, cnt_q};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (grant_mem) begin
          state_d = mem_we_i ? StWrite : StRead;
        end else if (grant_if) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (cnt_q == nbytes) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrite: begin
        if (cnt_q == nbytes - 3'd1) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output logic; RAM bus is idle-zero outside the active access states.
  always_comb begin
    busy      = (state_q != StIdle);
    if_done   = (state_q == StDone) && !owner_mem_q;
    mem_done  = (state_q == StDone) && owner_mem_q;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    unique case (state_q)
      StRead: begin
        ram_addr = cur_addr[ADDR_W-1:0];
      end
      StWrite: begin
        ram_addr = cur_addr[ADDR_W-1:0];
        ram_we   = 1'b1;
        unique case (cnt_q[1:0])
          2'd0:    ram_wdata = wdata_q[7:0];
          2'd1:    ram_wdata = wdata_q[15:8];
          2'd2:    ram_wdata = wdata_q[23:16];
          default: ram_wdata = wdata_q[31:24];
        endcase
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  // Merge the incoming read byte into its lane.
  always_comb begin
    asm_d = asm_q;
    if ((state_q == StRead) && (cnt_q != 3'd0)) begin
      unique case (beat_idx)
        2'd0:    asm_d[7:0]   = ram_rdata;
        2'd1:    asm_d[15:8]  = ram_rdata;
        2'd2:    asm_d[23:16] = ram_rdata;
        default: asm_d[31:24] = ram_rdata;
      endcase
    end
  end

  always_comb begin
    ext_data = asm_d;
    unique case (size_q)
      2'b00:   ext_data = {{24{sext_q & asm_d[7]}}, asm_d[7:0]};
      2'b01:   ext_data = {{16{sext_q & asm_d[15]}}, asm_d[15:0]};
      default: ext_data = asm_d;
    endcase
  end

  // Request latches, assembly register and per-owner result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= 32'd0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      wdata_q     <= 32'd0;
      owner_mem_q <= 1'b0;
      asm_q       <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      if (grant_mem) begin
        addr_q      <= mem_addr_i;
        size_q      <= mem_size;
        sext_q      <= mem_sext;
        wdata_q     <= mem_wdata_i;
        owner_mem_q <= 1'b1;
        asm_q       <= 32'd0;
      end else if (grant_if) begin
        addr_q      <= if_addr;
        size_q      <= 2'b10;
        sext_q      <= 1'b0;
        wdata_q     <= 32'd0;
        owner_mem_q <= 1'b0;
        asm_q       <= 32'd0;
      end else begin
        asm_q <= asm_d;
      end
      if (rd_last) begin
        if (owner_mem_q) begin
          mem_rdata_q <= ext_data;
        end else begin
          if_rdata_q <= ext_data;
        end
      end
    end
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller and arbiter shared by the instruction-fetch (IF) and memory-access (MEM) pipeline stages.
- Serialises 32-bit, 16-bit and 8-bit accesses onto a byte-wide synchronous RAM/UART bus, one byte per cycle, little-endian.
- Performs load sign/zero extension.
- Sits between the IF/MEM stages and the external memory; `busy` feeds the pipeline stall logic.

Parameters:
- ADDR_W, 32, width of `ram_addr`. Internal addresses are computed at 32 bits and truncated to the low ADDR_W bits.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst, in, 1, asynchronous active-low reset: rst==0 resets immediately.
- if_req, in, 1, IF requests a word read; held high until if_done.
- if_addr, in, 32, IF byte address.
- if_done, out, 1, one-cycle pulse when IF read data is valid.
- if_rdata, out, 32, IF read word.
- mem_req, in, 1, MEM requests a load or store; held high until mem_done.
- mem_we_i, in, 1, 1 = store, 0 = load.
- mem_size, in, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mem_sext, in, 1, load sign-extends when 1.
- mem_addr_i, in, 32, MEM byte address.
- mem_wdata_i, in, 32, store data, low bytes used.
- mem_done, out, 1, one-cycle completion pulse.
- mem_rdata, out, 32, extended load result.
- ram_addr, out, ADDR_W, byte address to RAM.
- ram_we, out, 1, RAM byte write enable.
- ram_wdata, out, 8, RAM write byte.
- ram_rdata, in, 8, RAM read byte, valid the cycle after its address was presented.
- busy, out, 1, high whenever state != IDLE.

Behaviour:
- States: IDLE, READ, WRITE, DONE.
  - 2-bit state register, 3-bit beat counter, latched request fields, 32-bit assembly register, owner bit (IF/MEM).
- Reset (rst==0, asynchronous):
  - State = IDLE; counters, latches, if_rdata, mem_rdata, if_done and mem_done = 0.
  - ram_we = 0, ram_addr = 0, ram_wdata = 0, busy = 0.
  - Reset mid-transaction aborts the access with no done pulse and no further RAM writes.
- IDLE arbitration, sampled at each rising edge:
  - mem_req has priority over if_req.
  - Grant latches addr, size, we, sext and wdata, and sets owner.
  - Next state: READ for IF or MEM loads, WRITE for stores.
  - No preemption. A request arriving during a transaction waits for IDLE.
- Byte count N: 1 for byte, 2 for half, 4 for word or size 11. IF is always N = 4.
- Byte addressing and lane mapping:
  - Byte k uses address base+k, with 32-bit wrap-around modulo 2^32, then truncated to ADDR_W.
  - Byte k maps to bits [8k+7:8k].
  - No alignment check.
- Cycle numbering: the grant edge is edge 0; cycle c lies between edge c-1 and edge c.
- READ:
  - Cycles 1..N: ram_addr = base+c-1, ram_we = 0.
  - Edges 2..N+1 capture ram_rdata into byte c-2.
  - Edge N+1 → DONE.
  - Result is extended per size and sext. Word results are unaffected by sext.
- WRITE:
  - Cycles 1..N: ram_we = 1, ram_addr = base+c-1, ram_wdata = wdata byte c-1.
  - Edge N → DONE.
- DONE (exactly one cycle):
  - The owner's done output is high for that cycle only.
  - The owner's rdata register updates at the edge entering DONE and holds until that owner's next completion.
  - Store completions leave mem_rdata unchanged.
  - No new grant in DONE. Next edge → IDLE.
- Latency from grant edge to done cycle:
  - Loads: cycle N+2 (word fetch: cycle 6).
  - Stores: cycle N+1 (word store: cycle 5).
  - Minimum back-to-back word-fetch period: 7 cycles.
- RAM outputs are combinational from registered state.
  - Outside WRITE: ram_we = 0 and ram_wdata = 0.
  - Outside READ/WRITE: ram_addr = 0.
- Requester protocol violations:
  - Dropping req or changing inputs after grant does not affect the transaction; latched values are used and done still pulses.
  - If req is held high after done, it is re-granted in IDLE.

Test Plan:
1. RAM[0x100..0x103] = 13,05,10,00; if_req, if_addr=0x100 → ram_addr 0x100..0x103 in cycles 1-4; if_done in cycle 6 only; if_rdata = 0x00100513; busy high in cycles 1-6.
2. if_req and mem_req (load, size 00, sext=1, addr 0x200, RAM=0x80) in the same cycle → MEM granted first; mem_done in cycle 3 with mem_rdata = 0xFFFFFF80; DONE; IF granted at the following IDLE edge; if_done 7 cycles later.
3. Store half 0x1234ABCD at 0x300 → ram_we high in cycles 1-2 writing 0xCD@0x300 and 0xAB@0x301; mem_done in cycle 3; subsequent lhu 0x300 returns 0x0000ABCD, lh returns 0xFFFFABCD.
4. Word load at 0xFFFFFFFE (ADDR_W=32) → ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
5. Word load at 0x100; rst=0 asynchronously mid-cycle 3 → outputs zero immediately, no mem_done; after release a new word store to 0x40 completes normally (mem_done in cycle 5).
6. mem_req held high across two loads; mem_req deasserted one cycle after grant → first transaction still completes with done; second is granted only after DONE→IDLE.
